// File: rtl/gain_meter_if.sv
// Sample-pair stream in and gain-result stream out of gain_meter.
// Both streams use valid/ready: a transfer happens on a rising clk edge where valid && ready are both high.
interface gain_meter_if #(
  parameter int W  = 16,
  parameter int OW = 16
);
  logic                s_valid;
  logic                s_ready;
  logic signed [W-1:0] s_in;
  logic signed [W-1:0] s_out;
  logic                m_valid;
  logic                m_ready;
  logic [OW-1:0]       gain;
  logic                ovf;
  logic                div0;

  modport master (
    output s_valid, s_in, s_out, m_ready,
    input  s_ready, m_valid, gain, ovf, div0
  );

  modport slave (
    input  s_valid, s_in, s_out, m_ready,
    output s_ready, m_valid, gain, ovf, div0
  );
endinterface

// File: rtl/gain_meter.sv
// Peak |out|/|in| gain meter over a 2^WIN_LOG2 window, restoring divider, Q(OW-FRAC).FRAC result.
// Optional GAIN_METER_ROUND_EN: one extra quotient bit and round-half-up instead of truncation.
module gain_meter #(
  parameter int W        = 16,
  parameter int WIN_LOG2 = 8,
  parameter int FRAC     = 8,
  parameter int OW       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  gain_meter_if.slave bus,
  output logic [1:0]  dbg_state
);
`ifdef GAIN_METER_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int NQ = W + FRAC + RND;
  localparam int CW = $clog2(NQ + 1);

  typedef enum logic [1:0] {ACCUM = 2'd0, DIVIDE = 2'd1, OUTPUT = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [W-1:0]        peak_in, peak_out;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [CW-1:0]       div_cnt;
  logic [W-1:0]        rem;
  logic [NQ-1:0]       dq;
  logic [OW-1:0]       gain_q;
  logic                ovf_q, div0_q;

  logic                accept, last_pair, div_last;
  logic [W-1:0]        mag_in, mag_out;
  logic [W:0]          shifted, rem_nxt;
  logic [W+1:0]        trial;
  logic                ge;
  logic [NQ-1:0]       dq_nxt;
  logic [NQ:0]         q_full;
  logic                q_big;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1) without saturation.
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? (~x + W'(1)) : x;
  endfunction

  assign mag_in    = mag(bus.s_in);
  assign mag_out   = mag(bus.s_out);
  assign accept    = bus.s_valid && (state == ACCUM);
  assign last_pair = accept && (win_cnt == '1);
  assign div_last  = (state == DIVIDE) && (div_cnt == CW'(NQ));

  // One restoring step: dq shifts the dividend out at the top and the quotient in at the bottom.
  always_comb begin
    shifted = {rem, dq[NQ-1]};
    trial   = {1'b0, shifted} - {2'b00, peak_in};
    ge      = ~trial[W+1];
    rem_nxt = ge ? trial[W:0] : shifted;
    dq_nxt  = {dq[NQ-2:0], ge};
`ifdef GAIN_METER_ROUND_EN
    q_full  = ({1'b0, dq_nxt} + (NQ+1)'(1)) >> 1;
`else
    q_full  = {1'b0, dq_nxt};
`endif
    q_big   = |q_full[NQ:OW];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.s_ready = 1'b0;
    bus.m_valid = 1'b0;
    case (state)
      ACCUM: begin
        bus.s_ready = 1'b1;
        if (last_pair) state_nxt = DIVIDE;
      end
      DIVIDE: begin
        if (div_last) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        bus.m_valid = 1'b1;
        if (bus.m_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_in  <= '0;
      peak_out <= '0;
      win_cnt  <= '0;
      div_cnt  <= '0;
      rem      <= '0;
      dq       <= '0;
      gain_q   <= '0;
      ovf_q    <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (mag_in > peak_in)   peak_in  <= mag_in;
            if (mag_out > peak_out) peak_out <= mag_out;
            win_cnt <= win_cnt + WIN_LOG2'(1);
            div_cnt <= '0;
          end
        end
        DIVIDE: begin
          // Count 0 loads the operands; counts 1..NQ each retire one quotient bit.
          if (div_cnt == '0) begin
            rem     <= '0;
            dq      <= {peak_out, {(NQ-W){1'b0}}};
            div_cnt <= CW'(1);
          end else begin
            rem     <= rem_nxt[W-1:0];
            dq      <= dq_nxt;
            div_cnt <= div_cnt + CW'(1);
            if (div_last) begin
              if (peak_in == '0) begin
                gain_q <= '1;
                ovf_q  <= 1'b0;
                div0_q <= 1'b1;
              end else if (q_big) begin
                gain_q <= '1;
                ovf_q  <= 1'b1;
                div0_q <= 1'b0;
              end else begin
                gain_q <= q_full[OW-1:0];
                ovf_q  <= 1'b0;
                div0_q <= 1'b0;
              end
            end
          end
        end
        OUTPUT: begin
          if (bus.m_ready) begin
            peak_in  <= '0;
            peak_out <= '0;
            win_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gain  = gain_q;
  assign bus.ovf   = ovf_q;
  assign bus.div0  = div0_q;
  assign dbg_state = state;
endmodule

// File: tb/tb_gain_meter.sv
// Bench for gain_meter with a 4-pair window; expected {div0, ovf, gain} words are queued as windows are sent.
module tb_gain_meter;
  localparam int W = 16, WIN_LOG2 = 2, FRAC = 8, OW = 16;
`ifdef GAIN_METER_ROUND_EN
  localparam int EXP_LAT = 26;
  localparam logic [17:0] EXP_RND = 18'd171;
`else
  localparam int EXP_LAT = 25;
  localparam logic [17:0] EXP_RND = 18'd170;
`endif

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gain_meter_if #(.W(W), .OW(OW)) bus ();

  gain_meter #(.W(W), .WIN_LOG2(WIN_LOG2), .FRAC(FRAC), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .dbg_state(dbg_state)
  );

  // ---- checking ----
  int n_tests = 0;
  int n_fail  = 0;
  int accept_cyc = 0;
  logic [17:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [17:0] model(input int ins[4], input int outs[4]);
    longint pin = 0, pout = 0, q;
    for (int i = 0; i < 4; i++) begin
      longint a = (ins[i] < 0) ? -ins[i] : ins[i];
      longint b = (outs[i] < 0) ? -outs[i] : outs[i];
      if (a > pin) pin = a;
      if (b > pout) pout = b;
    end
    if (pin == 0) return {2'b10, 16'hFFFF};
`ifdef GAIN_METER_ROUND_EN
    q = ((pout * 512) / pin + 1) / 2;
`else
    q = (pout * 256) / pin;
`endif
    if (q > 65535) return {2'b01, 16'hFFFF};
    return {2'b00, q[15:0]};
  endfunction

  // Scoreboard: compare on each result handshake.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("result", {14'd0, bus.div0, bus.ovf, bus.gain}, {14'd0, exp_q.pop_front()});
    end
  end

  // ---- drivers ----
  task automatic send_window(input int ins[4], input int outs[4], input logic [17:0] exp, input bit push);
    int n;
    if (push) exp_q.push_back(exp);
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1;
      bus.s_in    = 16'(ins[i]);
      bus.s_out   = 16'(outs[i]);
      n = 0;
      @(negedge clk);
      while (!bus.s_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!bus.s_ready) check("s_ready_wait", 32'(bus.s_ready), 32'd1);
      @(posedge clk);
      #1;
      accept_cyc = cyc;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n = 0;
    @(negedge clk);
    while (!bus.m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(cyc - accept_cyc), 32'(EXP_LAT));
  endtask

  task automatic set_m_ready(input logic v);
    @(posedge clk);
    #1;
    bus.m_ready = v;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 32'd1);
    check({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    check({tag, "_gain"}, 32'(bus.gain), 32'd0);
    check({tag, "_flags"}, {30'd0, bus.div0, bus.ovf}, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int ri[4], ro[4];
    bus.s_valid = 1'b0;
    bus.s_in    = '0;
    bus.s_out   = '0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    send_window('{100, 100, 100, 100}, '{-250, -250, -250, -250}, {2'b00, 16'h0280}, 1'b1);
    wait_result();
    send_window('{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768}, {2'b00, 16'h0100}, 1'b1);
    wait_result();
    send_window('{0, 5, -7, 3}, '{1, -20, 4, 0}, {2'b00, 16'h02DB}, 1'b1);
    wait_result();
    send_window('{0, 0, 0, 0}, '{10, 10, 10, 10}, {2'b10, 16'hFFFF}, 1'b1);
    wait_result();
    send_window('{1, 1, 1, 1}, '{32767, 32767, 32767, 32767}, {2'b01, 16'hFFFF}, 1'b1);
    wait_result();
    send_window('{3, 3, 3, 3}, '{2, 2, 2, 2}, EXP_RND, 1'b1);
    wait_result();

    // Backpressure: result must hold while a stray sample is offered and ignored.
    set_m_ready(1'b0);
    send_window('{3, 3, 3, 3}, '{2, 2, 2, 2}, EXP_RND, 1'b1);
    wait_result();
    @(posedge clk);
    #1;
    bus.s_valid = 1'b1;
    bus.s_in    = 16'sd1;
    bus.s_out   = 16'sd30000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_m_valid", 32'(bus.m_valid), 32'd1);
      check("hold_s_ready", 32'(bus.s_ready), 32'd0);
      check("hold_result", {14'd0, bus.div0, bus.ovf, bus.gain}, {14'd0, EXP_RND});
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    send_window('{10, 10, 10, 10}, '{10, 10, 10, 10}, {2'b00, 16'h0100}, 1'b1);
    wait_result();

    // Reset during the 5th divide cycle discards the window.
    send_window('{100, 100, 100, 100}, '{-250, -250, -250, -250}, 18'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("mid_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_window('{100, 100, 100, 100}, '{-250, -250, -250, -250}, {2'b00, 16'h0280}, 1'b1);
    wait_result();

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin
        ri[i] = int'($urandom_range(0, 4000)) - 2000;
        ro[i] = int'($urandom_range(0, 20000)) - 10000;
      end
      send_window(ri, ro, model(ri, ro), 1'b1);
      wait_result();
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
